down_counter_timer: RTL and testbench
=====================================

DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
- REQ-001 SHALL have parameter WIDTH, default 32: width of count, load value and reload register.
- REQ-002 SHALL have parameter PSC_WIDTH, default 8: prescaler width; used only when TIMER_PRESCALER_EN is defined.
- REQ-003 SHALL use one clock; reset is asynchronous and active-low.
- REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
- REQ-005 resetn  input  1  asynchronous active-low reset.
- REQ-006 load_valid  input  1  load request; transfers when load_valid && load_ready at a clk edge.
- REQ-007 load_ready  output  1  high in IDLE and LOADED, low in RUN.
- REQ-008 load_value  input  WIDTH  value for count and reload register.
- REQ-009 auto_reload  input  1  sampled only on a load transfer; 1 = periodic mode.
- REQ-010 start  input  1  single-cycle run request.
- REQ-011 stop  input  1  single-cycle pause request.
- REQ-012 irq_clr  input  1  clears irq.
- REQ-013 psc_div  input  PSC_WIDTH  tick divider, used live; present only with TIMER_PRESCALER_EN.
- REQ-014 count  output  WIDTH  current counter value.
- REQ-015 busy  output  1  high exactly in RUN.
- REQ-016 expired  output  1  registered one-cycle pulse on each expiry.
- REQ-017 irq  output  1  sticky expiry flag.

Function
- REQ-018 States SHALL be IDLE, LOADED, RUN; a load transfer is the only exit from IDLE.
- REQ-019 Load transfer (IDLE or LOADED) SHALL set count and reload to load_value, latch auto_reload, and enter LOADED the next cycle.
- REQ-020 In LOADED, start with count != 0 SHALL enter RUN; start with count == 0 SHALL be ignored.
- REQ-021 In LOADED, a load transfer and start in the same cycle SHALL perform the load and ignore start.
- REQ-022 In RUN, each tick with count > 1 SHALL decrement count by 1.
- REQ-023 In RUN, a tick with count == 1 is expiry: expired = 1 for the next cycle only; irq set to 1.
- REQ-024 On expiry with latched auto_reload = 1, count SHALL become reload and state stays RUN, with no dead cycle.
- REQ-025 On expiry with latched auto_reload = 0, count SHALL become 0 and state SHALL become IDLE.
- REQ-026 stop in RUN SHALL enter LOADED with count held and no decrement or expiry that cycle; stop outside RUN SHALL be ignored.
- REQ-027 start and stop in the same cycle: stop wins.
- REQ-028 irq_clr SHALL clear irq; if irq_clr and expiry fall in the same cycle, irq SHALL be 1 (set wins).
- REQ-029 Latency: with tick every cycle, start accepted at edge k on load N SHALL give count N-1 after edge k+1 and expired high in the cycle after edge k+N.
- REQ-030 load_valid in RUN SHALL be ignored (load_ready = 0); there is no queued load.

Reset
- REQ-031 resetn low SHALL immediately force IDLE, count = 0, reload = 0, latched auto_reload = 0, prescaler count = 0, expired = 0, irq = 0, busy = 0, load_ready = 1.
- REQ-032 Reset asserted mid-RUN SHALL abort without an expired pulse; after release, operation SHALL resume only through a new load transfer.

Configuration
- REQ-033 Macro TIMER_PRESCALER_EN: when defined, tick SHALL occur when the prescaler count equals psc_div; the prescaler count then wraps to 0, otherwise it increments in RUN and resets to 0 outside RUN or on stop. The period is psc_div+1 cycles.
- REQ-034 When TIMER_PRESCALER_EN is undefined, psc_div port and prescaler logic SHALL be absent and tick = 1 every RUN cycle.

Verification
- REQ-035 Load 5, auto_reload=0, start -> count 4,3,2,1,0 on successive cycles; expired pulses once; irq=1; busy falls; state IDLE.
- REQ-036 Load 3, auto_reload=1, run 10 cycles -> expired pulses every 3 cycles; count sequence 2,1,3,2,1,3...; busy stays 1.
- REQ-037 Load 10, start, stop after 4 cycles -> count holds 6 and load_ready=1; start -> count 5 and decrementing resumes.
- REQ-038 Expiry and irq_clr in the same cycle -> irq stays 1; irq_clr next cycle -> irq 0.
- REQ-039 With TIMER_PRESCALER_EN, psc_div=3, load 2, start -> expired 8 cycles after start.
- REQ-040 resetn low mid-RUN at count 7 -> all outputs reset immediately with no expired pulse; start after release is ignored until a load.

Source files
------------

// File: rtl/down_counter_timer_if.sv
// Load/control/status bundle for down_counter_timer.
// psc_div exists only when TIMER_PRESCALER_EN is defined.
interface down_counter_timer_if #(
  parameter int WIDTH     = 32,
  parameter int PSC_WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             auto_reload;
  logic             start;
  logic             stop;
  logic             irq_clr;
`ifdef TIMER_PRESCALER_EN
  logic [PSC_WIDTH-1:0] psc_div;
`endif
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             expired;
  logic             irq;

  modport master (
`ifdef TIMER_PRESCALER_EN
    output psc_div,
`endif
    output load_valid, load_value, auto_reload, start, stop, irq_clr,
    input  load_ready, count, busy, expired, irq
  );

  modport slave (
`ifdef TIMER_PRESCALER_EN
    input  psc_div,
`endif
    input  load_valid, load_value, auto_reload, start, stop, irq_clr,
    output load_ready, count, busy, expired, irq
  );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with one-shot/periodic modes and sticky irq.
// Define TIMER_PRESCALER_EN to add a live psc_div tick divider.
module down_counter_timer #(
  parameter int WIDTH     = 32,
  parameter int PSC_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  down_counter_timer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LOADED, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             ar_q, ar_d;
  logic             expired_q, expired_d;
  logic             irq_q, irq_d;
  logic             busy_q, ready_q;
  logic             tick;
  logic             load_xfer;

`ifdef TIMER_PRESCALER_EN
  logic [PSC_WIDTH-1:0] psc_q, psc_d;

  // Prescaler only advances while actually running; stop or leaving RUN clears it.
  always_comb begin
    psc_d = '0;
    tick  = 1'b0;
    if (state_q == RUN && !bus.stop) begin
      tick  = (psc_q == bus.psc_div);
      psc_d = tick ? '0 : psc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) psc_q <= '0;
    else         psc_q <= psc_d;
  end
`else
  assign tick = 1'b1;
`endif

  assign load_xfer = bus.load_valid && ready_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    ar_d      = ar_q;
    expired_d = 1'b0;
    case (state_q)
      IDLE, LOADED: begin
        if (load_xfer) begin
          count_d  = bus.load_value;
          reload_d = bus.load_value;
          ar_d     = bus.auto_reload;
          state_d  = LOADED;
        end else if (state_q == LOADED && bus.start && !bus.stop && count_q != '0) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = LOADED;
        end else if (tick) begin
          // Expiry reloads in the same edge so periodic mode has no dead cycle.
          if (count_q == WIDTH'(1)) begin
            expired_d = 1'b1;
            count_d   = ar_q ? reload_q : '0;
            state_d   = ar_q ? RUN : IDLE;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    irq_d = expired_d | (irq_q & ~bus.irq_clr);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      ar_q      <= 1'b0;
      expired_q <= 1'b0;
      irq_q     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      ar_q      <= ar_d;
      expired_q <= expired_d;
      irq_q     <= irq_d;
      busy_q    <= (state_d == RUN);
      ready_q   <= (state_d != RUN);
    end
  end

  assign bus.count      = count_q;
  assign bus.busy       = busy_q;
  assign bus.load_ready = ready_q;
  assign bus.expired    = expired_q;
  assign bus.irq        = irq_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: directed scenarios plus random traffic.
`timescale 1ns/1ps
module tb_down_counter_timer;
  localparam int W = 32;
  localparam int P = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  down_counter_timer_if #(.WIDTH(W), .PSC_WIDTH(P)) bus ();
  down_counter_timer #(.WIDTH(W), .PSC_WIDTH(P)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic [P-1:0] div = '0;
`ifdef TIMER_PRESCALER_EN
  assign bus.psc_div = div;
`endif

  typedef struct packed {
    logic [W-1:0] count;
    logic         busy;
    logic         ready;
    logic         expired;
    logic         irq;
  } obs_t;

  obs_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  typedef enum int {M_IDLE, M_ARMED, M_RUN} mode_t;
  mode_t        m_mode = M_IDLE;
  logic [W-1:0] m_cnt  = '0;
  logic [W-1:0] m_rel  = '0;
  bit           m_ar   = 1'b0;
  bit           m_irq  = 1'b0;
  int           m_phase = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d want %0d at %0t", nm, act, expv, $time);
  endtask

  // Reference: predicts the visible outputs after the coming clock edge.
  task automatic model_step(input bit lv, input logic [W-1:0] val, input bit ar,
                            input bit st, input bit sp, input bit clr, input bit rst);
    obs_t o;
    bit   fire = 1'b0;
    bit   tick = 1'b1;
    if (rst) begin
      m_mode = M_IDLE; m_cnt = '0; m_rel = '0; m_ar = 1'b0; m_irq = 1'b0; m_phase = 0;
    end else begin
      if (m_mode == M_RUN) begin
        if (sp) begin
          m_mode = M_ARMED; m_phase = 0;
        end else begin
`ifdef TIMER_PRESCALER_EN
          tick    = (m_phase == int'(div));
          m_phase = tick ? 0 : (m_phase + 1) % (1 << P);
`endif
          if (tick) begin
            if (m_cnt == 1) begin
              fire = 1'b1;
              if (m_ar) m_cnt = m_rel;
              else begin m_cnt = '0; m_mode = M_IDLE; end
            end else begin
              m_cnt = m_cnt - 1;
            end
          end
        end
      end else if (lv) begin
        m_cnt = val; m_rel = val; m_ar = ar; m_mode = M_ARMED;
      end else if (m_mode == M_ARMED && st && !sp && m_cnt != 0) begin
        m_mode = M_RUN; m_phase = 0;
      end
      m_irq = fire | (m_irq & !clr);
    end
    o.count = m_cnt; o.busy = (m_mode == M_RUN); o.ready = (m_mode != M_RUN);
    o.expired = fire; o.irq = m_irq;
    exp_q.push_back(o);
  endtask

  task automatic drive(input bit lv, input logic [W-1:0] val, input bit ar,
                       input bit st, input bit sp, input bit clr, input bit rst);
    @(negedge clk);
    bus.load_valid = lv; bus.load_value = val; bus.auto_reload = ar;
    bus.start = st; bus.stop = sp; bus.irq_clr = clr;
    resetn = !rst;
    if (rst) begin
      #1;
      chk("rst_count", bus.count, '0);
      chk("rst_flags", {28'd0, bus.busy, bus.load_ready, bus.expired, bus.irq}, 32'b0100);
    end
    model_step(lv, val, ar, st, sp, clr, rst);
  endtask

  task automatic nop();                          drive(0, '0, 0, 0, 0, 0, 0); endtask
  task automatic ld(input logic [W-1:0] v, input bit a); drive(1, v, a, 0, 0, 0, 0); endtask
  task automatic go();                           drive(0, '0, 0, 1, 0, 0, 0); endtask
  task automatic sp();                           drive(0, '0, 0, 0, 1, 0, 0); endtask
  task automatic clr();                          drive(0, '0, 0, 0, 0, 1, 0); endtask
  task automatic rst();                          drive(0, '0, 0, 0, 0, 0, 1); endtask
  task automatic post();                         @(posedge clk); #2; endtask

  always @(posedge clk) begin
    obs_t e;
    obs_t a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.count, bus.busy, bus.load_ready, bus.expired, bus.irq};
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL sb t=%0t: got cnt=%0d busy=%b rdy=%b exp=%b irq=%b want cnt=%0d busy=%b rdy=%b exp=%b irq=%b",
                    $time, a.count, a.busy, a.ready, a.expired, a.irq,
                    e.count, e.busy, e.ready, e.expired, e.irq);
    end
  end

  initial begin
    bus.load_valid = 0; bus.load_value = '0; bus.auto_reload = 0;
    bus.start = 0; bus.stop = 0; bus.irq_clr = 0;
    rst(); rst();
    nop();

    // One-shot load 5.
    ld(5, 0); go();
    for (int i = 0; i < 5; i++) begin
      nop(); post(); chk("os_cnt", bus.count, W'(4 - i));
    end
    chk("os_exp", bus.expired, 1); chk("os_busy", bus.busy, 0); chk("os_irq", bus.irq, 1);
    nop(); post(); chk("os_pulse", bus.expired, 0);
    clr();

    // Periodic load 3.
    ld(3, 1); go();
    for (int i = 0; i < 10; i++) begin
      nop(); post();
      chk("per_cnt", bus.count, (i % 3 == 2) ? W'(3) : W'(2 - (i % 3)));
      chk("per_busy", bus.busy, 1);
    end
    sp(); clr();

    // Pause and resume.
    ld(10, 0); go();
    repeat (4) nop();
    sp(); post(); chk("pause_cnt", bus.count, 6); chk("pause_rdy", bus.load_ready, 1);
    go(); post(); chk("resume_cnt0", bus.count, 6);
    nop(); post(); chk("resume_cnt1", bus.count, 5);
    sp();

    // irq_clr coinciding with expiry.
    ld(2, 0); go(); nop();
    clr(); post(); chk("clr_same_irq", bus.irq, 1); chk("clr_same_exp", bus.expired, 1);
    clr(); post(); chk("clr_next_irq", bus.irq, 0);

`ifdef TIMER_PRESCALER_EN
    div = 3;
    ld(2, 0); go();
    for (int i = 1; i <= 8; i++) begin
      nop(); post(); chk("psc_exp", bus.expired, (i == 8) ? 1 : 0);
    end
    div = 0;
`endif

    // Reset mid-run.
    ld(10, 0); go(); repeat (3) nop();
    post(); chk("mid_cnt", bus.count, 7);
    rst(); post(); chk("mid_exp", bus.expired, 0);
    nop();
    go(); post(); chk("post_rst_busy", bus.busy, 0); chk("post_rst_cnt", bus.count, 0);
    ld(4, 0); go(); post(); chk("reload_busy", bus.busy, 1);

    for (int i = 0; i < 3000; i++) begin
`ifdef TIMER_PRESCALER_EN
      if ($urandom_range(0, 49) == 0) div = P'($urandom_range(0, 3));
`endif
      drive(($urandom_range(0, 7) == 0), W'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 199) == 0));
    end

    nop();
    repeat (3) @(negedge clk);
    chk("drain", W'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
